// File: rtl/vj_ii_rect_ram.sv
// vj_ii_rect_ram
//   Integral-image store for the Viola-Jones path with a rectangle-sum query
//   channel. A request (x, y, w, h) is expanded into four corner reads
//   A, B, C, D of the integral image and answered with D - B - C + A.
//   Row stride is IMG_W+1 because column 0 and row 0 hold zero padding.
//
//   Optional build macro: VJ_II_WR_BYPASS_EN
//     undefined : read-first on a same-cycle read/write to one address
//     defined   : write-first, wr_data is forwarded onto the read data
module vj_ii_rect_ram #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 17,
    parameter int COORD_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    input  logic [COORD_W-1:0] req_w,
    input  logic [COORD_W-1:0] req_h,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_sum,
    output logic               rsp_err
);

    localparam int STRIDE_I = IMG_W + 1;
    localparam int DEPTH    = STRIDE_I * (IMG_H + 1);

    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(STRIDE_I);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [COORD_W:0]  X_LIM     = (COORD_W + 1)'(IMG_W);
    localparam logic [COORD_W:0]  Y_LIM     = (COORD_W + 1)'(IMG_H);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        ISSUE_B,
        ISSUE_C,
        ISSUE_D,
        CAP_D,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata;
    logic              rd_en;
    logic [ADDR_W-1:0] raddr;

    logic [ADDR_W-1:0] addr_a, addr_b, addr_c, addr_d;
    logic [ADDR_W-1:0] nxt_a, nxt_c, row_top, row_bot;
    logic [DATA_W-1:0] cap_a, cap_b, cap_c;

    logic [COORD_W:0]  x_end, y_end;
    logic              req_bad;
    logic              accept;
    logic              wr_in_range;

    // Bounds are evaluated one bit wider than the fields so x+w cannot wrap.
    assign x_end   = {1'b0, req_x} + {1'b0, req_w};
    assign y_end   = {1'b0, req_y} + {1'b0, req_h};
    assign req_bad = (req_w == '0) || (req_h == '0) ||
                     (x_end > X_LIM) || (y_end > Y_LIM);

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);

    assign row_top = ADDR_W'(req_y) * STRIDE;
    assign row_bot = ADDR_W'(y_end) * STRIDE;
    assign nxt_a   = row_top + ADDR_W'(req_x);
    assign nxt_c   = row_bot + ADDR_W'(req_x);

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);

    // Write port: out-of-range writes are dropped; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (rd_en) begin
`ifdef VJ_II_WR_BYPASS_EN
            if (wr_en && (wr_addr == raddr)) begin
                rdata <= wr_data;
            end else begin
                rdata <= mem[raddr];
            end
`else
            rdata <= mem[raddr];
`endif
        end
    end

    // Corner addresses are derived once, at acceptance, from the request fields.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_a <= nxt_a;
            addr_b <= nxt_a + ADDR_W'(req_w);
            addr_c <= nxt_c;
            addr_d <= nxt_c + ADDR_W'(req_w);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and corner read sequencing.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        raddr     = addr_a;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_bad ? RESP : ISSUE_A;
                end
            end
            ISSUE_A: begin
                rd_en     = 1'b1;
                raddr     = addr_a;
                state_nxt = ISSUE_B;
            end
            ISSUE_B: begin
                rd_en     = 1'b1;
                raddr     = addr_b;
                state_nxt = ISSUE_C;
            end
            ISSUE_C: begin
                rd_en     = 1'b1;
                raddr     = addr_c;
                state_nxt = ISSUE_D;
            end
            ISSUE_D: begin
                rd_en     = 1'b1;
                raddr     = addr_d;
                state_nxt = CAP_D;
            end
            CAP_D: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Corner capture: each read lands one state after it was issued.
    always_ff @(posedge clk) begin
        case (state)
            ISSUE_B: cap_a <= rdata;
            ISSUE_C: cap_b <= rdata;
            ISSUE_D: cap_c <= rdata;
            default: ;
        endcase
    end

    // Response registers, held stable through RESP until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sum <= '0;
            rsp_err <= 1'b0;
        end else if (accept && req_bad) begin
            rsp_sum <= '0;
            rsp_err <= 1'b1;
        end else if (state == CAP_D) begin
            rsp_sum <= rdata - cap_b - cap_c + cap_a;
            rsp_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vj_ii_rect_ram.sv
// tb_vj_ii_rect_ram
//   Directed cases with literal expectations, then randomized writes,
//   requests and response backpressure, all checked every cycle against a
//   behavioural model of the rectangle-sum store.
//   Honors VJ_II_WR_BYPASS_EN for the expected collision behaviour.
module tb_vj_ii_rect_ram;

    localparam int IMG_W   = 320;
    localparam int IMG_H   = 240;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 17;
    localparam int COORD_W = 9;
    localparam int S       = IMG_W + 1;
    localparam int DEPTH   = S * (IMG_H + 1);
    localparam int RX      = 64;   // preloaded region columns 0..RX
    localparam int RY      = 48;   // preloaded region rows 0..RY

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               req_valid;
    logic               req_ready;
    logic [COORD_W-1:0] req_x, req_y, req_w, req_h;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_sum;
    logic               rsp_err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    vj_ii_rect_ram #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mm [DEPTH];
    bit          m_started = 1'b0;
    bit          m_busy    = 1'b0;
    bit          m_resp    = 1'b0;
    int          m_ph      = 0;
    logic [31:0] m_sum     = '0;
    bit          m_err     = 1'b0;
    int          m_corner [4];
    logic [31:0] m_cv     [4];

    function automatic bit is_bad(int x, int y, int w, int h);
        return (w == 0) || (h == 0) || (x + w > IMG_W) || (y + h > IMG_H);
    endfunction

    function automatic logic [31:0] model_read(int a);
`ifdef VJ_II_WR_BYPASS_EN
        if (wr_en && (int'(wr_addr) == a)) return wr_data;
`endif
        return mm[a];
    endfunction

    // Checks outputs mid-cycle, then advances the model across the next edge.
    initial begin
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("req_ready", req_ready, !rst && !m_busy && !m_resp);
                check("rsp_valid", rsp_valid, m_resp);
                check("rsp_sum",   rsp_sum,   m_sum);
                check("rsp_err",   rsp_err,   m_err);
            end
            if (rst) begin
                m_busy = 1'b0; m_resp = 1'b0; m_sum = '0; m_err = 1'b0;
                m_started = 1'b1;
            end else if (m_busy) begin
                m_ph++;
                if (m_ph <= 4) m_cv[m_ph-1] = model_read(m_corner[m_ph-1]);
                if (m_ph == 5) begin
                    m_sum  = m_cv[3] - m_cv[1] - m_cv[2] + m_cv[0];
                    m_err  = 1'b0;
                    m_busy = 1'b0;
                    m_resp = 1'b1;
                end
            end else if (m_resp) begin
                if (rsp_ready) m_resp = 1'b0;
            end else if (req_valid) begin
                if (is_bad(req_x, req_y, req_w, req_h)) begin
                    m_resp = 1'b1; m_sum = '0; m_err = 1'b1;
                end else begin
                    m_corner[0] = req_y * S + req_x;
                    m_corner[1] = req_y * S + req_x + req_w;
                    m_corner[2] = (req_y + req_h) * S + req_x;
                    m_corner[3] = (req_y + req_h) * S + req_x + req_w;
                    m_busy = 1'b1;
                    m_ph   = 0;
                end
            end
            if (wr_en && (int'(wr_addr) < DEPTH)) mm[wr_addr] = wr_data;
        end
    end

    // ---------------- driver ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int x, input int y, input int w, input int h, output int waited);
        waited = 0;
        while (!req_ready && waited < 20) begin
            tick;
            waited++;
        end
        req_x = COORD_W'(x); req_y = COORD_W'(y);
        req_w = COORD_W'(w); req_h = COORD_W'(h);
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        req_x = COORD_W'($urandom); req_y = COORD_W'($urandom);
        req_w = COORD_W'($urandom); req_h = COORD_W'($urandom);
    endtask

    // Counts edges after the acceptance edge until rsp_valid is observed.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick;
            lat++;
        end
        check("rsp_arrived", rsp_valid, 1'b1);
    endtask

    task automatic ack;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic pl(input int x, input int y);
        wr_en = 1'b1; wr_addr = ADDR_W'(y * S + x); wr_data = 32'(x * y);
        tick;
    endtask

    initial begin
        int w8, lat;
        logic [31:0] hold;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_x = '0; req_y = '0; req_w = '0; req_h = '0;
        rsp_ready = 1'b1;
        repeat (3) tick;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_sum",   rsp_sum,   32'd0);
        check("rst_rsp_err",   rsp_err,   1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        rsp_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 1'b1);

        // Preload ii(x,y) = x*y (all-ones image) over the test region and frame corners.
        for (int y = 0; y <= RY; y++)
            for (int x = 0; x <= RX; x++) pl(x, y);
        pl(320, 0); pl(0, 240); pl(320, 240);
        pl(319, 239); pl(320, 239); pl(319, 240);
        wr_en = 1'b0;
        tick;

        // Basic query plus response backpressure.
        send_req(10, 20, 24, 24, w8);
        wait_rsp(lat);
        check("lat_valid", lat, 5);
        check("sum_10_20_24_24", rsp_sum, 576);
        check("err_10_20_24_24", rsp_err, 0);
        hold = rsp_sum;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("bp_sum_stable", rsp_sum, hold);
            check("bp_valid_held", rsp_valid, 1'b1);
            check("bp_ready_low", req_ready, 1'b0);
        end
        ack;
        check("idle_after_ack", req_ready, 1'b1);
        send_req(0, 0, 320, 240, w8);
        check("b2b_no_wait", w8, 0);
        wait_rsp(lat);
        check("sum_full_frame", rsp_sum, 76800);
        check("err_full_frame", rsp_err, 0);
        ack;
        send_req(319, 239, 1, 1, w8);
        wait_rsp(lat);
        check("sum_last_pixel", rsp_sum, 1);
        ack;

        // Invalid requests answer at once with an error and a zero sum.
        send_req(300, 0, 21, 1, w8);
        wait_rsp(lat);
        check("lat_invalid_oob", lat, 0);
        check("sum_invalid_oob", rsp_sum, 0);
        check("err_invalid_oob", rsp_err, 1);
        ack;
        check("invalid_spacing_ready", req_ready, 1'b1);
        send_req(5, 5, 0, 3, w8);
        check("invalid_b2b_no_wait", w8, 0);
        wait_rsp(lat);
        check("lat_invalid_zero", lat, 0);
        check("sum_invalid_zero", rsp_sum, 0);
        check("err_invalid_zero", rsp_err, 1);
        ack;

        // Write corner A during the cycle its read is issued.
        send_req(10, 20, 24, 24, w8);
        wr_en = 1'b1; wr_addr = ADDR_W'(20 * S + 10); wr_data = 32'd1000;
        tick;
        wr_en = 1'b0;
        wait_rsp(lat);
`ifdef VJ_II_WR_BYPASS_EN
        check("collision_sum", rsp_sum, 1376);
`else
        check("collision_sum", rsp_sum, 576);
`endif
        ack;

        // Reset while the C corner read is being issued.
        send_req(5, 5, 10, 10, w8);
        tick;
        tick;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        check("ready_after_abort", req_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick;
            check("no_rsp_after_abort", rsp_valid, 1'b0);
        end
        send_req(0, 0, 2, 2, w8);
        wait_rsp(lat);
        check("sum_after_reset", rsp_sum, 4);
        check("err_after_reset", rsp_err, 0);
        ack;

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            int x, y, k;
            wr_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0)
                wr_addr = ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1));
            else
                wr_addr = ADDR_W'($urandom_range(0, RY) * S + $urandom_range(0, RX));
            wr_data = $urandom;
            rsp_ready = ($urandom_range(0, 1) == 1);
            req_valid = ($urandom_range(0, 2) == 0);
            k = $urandom_range(0, 9);
            if (k < 7) begin
                x = $urandom_range(0, RX - 1);
                y = $urandom_range(0, RY - 1);
                req_x = COORD_W'(x); req_w = COORD_W'($urandom_range(1, RX - x));
                req_y = COORD_W'(y); req_h = COORD_W'($urandom_range(1, RY - y));
            end else if (k == 7) begin
                req_x = COORD_W'($urandom); req_y = COORD_W'($urandom);
                req_w = '0;                 req_h = COORD_W'($urandom);
            end else if (k == 8) begin
                req_x = COORD_W'($urandom_range(300, 511)); req_w = COORD_W'($urandom_range(21, 511));
                req_y = COORD_W'($urandom_range(0, 200));   req_h = COORD_W'($urandom_range(1, 40));
            end else begin
                req_x = COORD_W'($urandom_range(0, 100));   req_w = COORD_W'($urandom_range(0, 100));
                req_y = COORD_W'($urandom_range(220, 511)); req_h = COORD_W'($urandom_range(21, 511));
            end
            tick;
        end
        req_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
        repeat (10) tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
